// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier display path: converter FSM states,
// BCD digit type, and the active-low seven-segment encodings (bit 6 = g ... bit 0 = a).
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // True when DIGITS decimal digits can hold the largest magnitude 2**(WIDTH-1).
    function automatic bit digits_fit(input int unsigned digits, input int unsigned width);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p > (64'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/product_bcd_converter_if.sv
// Handshake and result bus between the multiplier (master) and the BCD converter (slave).
// Hex segment outputs exist only when SEVSEG_OUT_EN is defined.
interface product_bcd_converter_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
);
    logic                  Start;
    logic [WIDTH-1:0]      Product;
    logic                  Busy;
    logic                  Done;
    logic                  Neg;
    logic [4*DIGITS-1:0]   Bcd;
`ifdef SEVSEG_OUT_EN
    logic [6:0]            Hex [DIGITS];
`endif

    modport master (
        output Start, Product,
        input  Busy, Done, Neg, Bcd
`ifdef SEVSEG_OUT_EN
        , input Hex
`endif
    );

    modport slave (
        input  Start, Product,
        output Busy, Done, Neg, Bcd
`ifdef SEVSEG_OUT_EN
        , output Hex
`endif
    );
endinterface

// File: rtl/product_bcd_converter_sevenseg.sv
// One BCD digit to active-low seven segments, with blank and minus overrides.
module bcd_sevenseg
    import mult_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg_c
);
    always_comb begin
        seg_c = SEG_LUT[digit];
        if (minus) begin
            seg_c = SEG_MINUS;
        end else if (blank) begin
            seg_c = SEG_BLANK;
        end
    end
endmodule

// File: rtl/product_bcd_converter.sv
// Signed product to sign + BCD magnitude, sequential double-dabble one bit per clock.
// Optional registered seven-segment outputs when SEVSEG_OUT_EN is defined.
module product_bcd_converter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                   Clk,
    input  logic                   Reset,
    product_bcd_converter_if.slave bus
);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (!digits_fit(DIGITS, WIDTH)) begin : g_range_err
        $error("product_bcd_converter: DIGITS too small for WIDTH");
    end

    conv_state_t      state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             sgn_q, sgn_d;
    logic [BW-1:0]    work_q, work_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [BW-1:0]    adj;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mag_d   = mag_q;
        sgn_d   = sgn_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        adj     = work_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    mag_d   = bus.Product[WIDTH-1] ? (~bus.Product + WIDTH'(1)) : bus.Product;
                    sgn_d   = bus.Product[WIDTH-1];
                    work_d  = '0;
                    count_d = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d  = {adj[BW-2:0], mag_q[WIDTH-1]};
                mag_d   = {mag_q[WIDTH-2:0], 1'b0};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = work_q;
                neg_d   = sgn_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            mag_q   <= '0;
            sgn_q   <= 1'b0;
            work_q  <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mag_q   <= mag_d;
            sgn_q   <= sgn_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.Neg  = neg_q;
    assign bus.Bcd  = bcd_q;

`ifdef SEVSEG_OUT_EN
    logic [DIGITS-1:0] blank;
    logic [DIGITS-1:0] minus;
    logic              lead;
    logic [6:0]        seg   [DIGITS];
    logic [6:0]        hex_q [DIGITS];

    // Leading-zero blanking; the minus sits in the blanked digit next to the number.
    always_comb begin
        lead  = 1'b1;
        blank = '0;
        minus = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead     = lead && (bcd_q[4*i +: 4] == 4'd0);
            blank[i] = (i != 0) && lead;
        end
        for (int i = 1; i < DIGITS; i++) begin
            minus[i] = neg_q && blank[i] && !blank[i-1];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd_sevenseg u_seg (
            .digit (bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .minus (minus[g]),
            .seg_c (seg[g])
        );
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < DIGITS; i++) begin
            if (Reset) begin
                hex_q[i] <= (i == 0) ? SEG_LUT[0] : SEG_BLANK;
            end else begin
                hex_q[i] <= seg[i];
            end
        end
    end

    assign bus.Hex = hex_q;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter with a result scoreboard; Hex checks
// are included when SEVSEG_OUT_EN is defined.
module tb_product_bcd_converter;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGITS = 5;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    product_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_if ();

    product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_if)
    );

    int unsigned total    = 0;
    int unsigned passed   = 0;
    int unsigned done_cnt = 0;
    int unsigned dc;
    logic [20:0] sb [$];
    logic [20:0] exp_mon;
    logic        busy_prev = 1'b0;
    logic [20:0] res_prev  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: sign bit plus decimal digits of |p| by repeated division.
    function automatic logic [20:0] model(input logic [15:0] p);
        int unsigned m;
        logic [19:0] r;
        m = p[15] ? (32'h10000 - 32'(p)) : 32'(p);
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {p[15], r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] p, input bit accept);
        bus_if.Start   = 1'b1;
        bus_if.Product = p;
        if (accept) sb.push_back(model(p));
        step();
        bus_if.Start   = 1'b0;
        bus_if.Product = 16'($urandom);
    endtask

    task automatic wait_result();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        check("result_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard pop on Done, plus result stability while busy.
    always @(negedge clk) begin
        if (bus_if.Done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_mon = sb.pop_front();
                check("result", 32'({bus_if.Neg, bus_if.Bcd}), 32'(exp_mon));
            end
        end
        if (bus_if.Busy && busy_prev) begin
            check("stable_while_busy", 32'({bus_if.Neg, bus_if.Bcd}), 32'(res_prev));
        end
        busy_prev = bus_if.Busy;
        res_prev  = {bus_if.Neg, bus_if.Bcd};
    end

    initial begin
        rst            = 1'b1;
        bus_if.Start   = 1'b0;
        bus_if.Product = '0;
        repeat (2) step();
        check("rst_busy", 32'(bus_if.Busy), 32'd0);
        check("rst_done", 32'(bus_if.Done), 32'd0);
        check("rst_neg",  32'(bus_if.Neg),  32'd0);
        check("rst_bcd",  32'(bus_if.Bcd),  32'd0);
        rst = 1'b0;
        step();

        // Latency and sign for -3
        start(16'hFFFD, 1'b1);
        repeat (16) step();
        check("lat_busy_n16", 32'(bus_if.Busy), 32'd1);
        check("lat_done_n16", 32'(bus_if.Done), 32'd0);
        step();
        check("lat_done_n17", 32'(bus_if.Done), 32'd1);
        check("lat_busy_n17", 32'(bus_if.Busy), 32'd0);
        check("m3_bcd", 32'(bus_if.Bcd), 32'h00003);
        check("m3_neg", 32'(bus_if.Neg), 32'd1);
        wait_result();
`ifdef SEVSEG_OUT_EN
        step();
        check("m3_hex0", 32'(bus_if.Hex[0]), 32'h30);
        check("m3_hex1", 32'(bus_if.Hex[1]), 32'h3F);
        check("m3_hex2", 32'(bus_if.Hex[2]), 32'h7F);
        check("m3_hex3", 32'(bus_if.Hex[3]), 32'h7F);
        check("m3_hex4", 32'(bus_if.Hex[4]), 32'h7F);
`endif

        start(16'h4000, 1'b1);
        wait_result();
        check("p4000_bcd", 32'(bus_if.Bcd), 32'h16384);
        check("p4000_neg", 32'(bus_if.Neg), 32'd0);

        start(16'hC080, 1'b1);
        wait_result();
        check("pC080_bcd", 32'(bus_if.Bcd), 32'h16256);
        check("pC080_neg", 32'(bus_if.Neg), 32'd1);

        // Start while busy is ignored
        dc = done_cnt;
        start(16'h0007, 1'b1);
        repeat (4) step();
        start(16'h0009, 1'b0);
        wait_result();
        repeat (3) step();
        check("busy_start_dones", done_cnt - dc, 32'd1);
        check("busy_start_bcd", 32'(bus_if.Bcd), 32'h00007);

        start(16'h0000, 1'b1);
        wait_result();
        step();
        check("zero_bcd", 32'(bus_if.Bcd), 32'h00000);
        check("zero_neg", 32'(bus_if.Neg), 32'd0);
`ifdef SEVSEG_OUT_EN
        check("zero_hex0", 32'(bus_if.Hex[0]), 32'h40);
        check("zero_hex1", 32'(bus_if.Hex[1]), 32'h7F);
        check("zero_hex4", 32'(bus_if.Hex[4]), 32'h7F);
`endif

        start(16'h8000, 1'b1);
        wait_result();
        check("p8000_bcd", 32'(bus_if.Bcd), 32'h32768);
        check("p8000_neg", 32'(bus_if.Neg), 32'd1);

        // Reset mid-conversion aborts without Done
        dc = done_cnt;
        start(16'h1234, 1'b0);
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(bus_if.Busy), 32'd0);
        check("abort_bcd",  32'(bus_if.Bcd),  32'd0);
        check("abort_neg",  32'(bus_if.Neg),  32'd0);
        check("abort_done", 32'(bus_if.Done), 32'd0);
        repeat (25) step();
        check("abort_no_done", done_cnt - dc, 32'd0);
        start(16'h0001, 1'b1);
        wait_result();
        check("after_abort_bcd", 32'(bus_if.Bcd), 32'h00001);

        // Reset wins over Start
        dc = done_cnt;
        rst            = 1'b1;
        bus_if.Start   = 1'b1;
        bus_if.Product = 16'h0005;
        step();
        rst          = 1'b0;
        bus_if.Start = 1'b0;
        check("rst_start_busy", 32'(bus_if.Busy), 32'd0);
        repeat (20) step();
        check("rst_start_busy_late", 32'(bus_if.Busy), 32'd0);
        check("rst_start_no_done", done_cnt - dc, 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
